// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: req/gnt request phase plus rvalid read response.
// Latency: n/a (signal bundle only).
// Backpressure: the master holds mem_req with stable address/data until the slave returns mem_gnt.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: RV32I loads/stores over a req/gnt/rvalid port, load data aligned and extended for writeback.
// Latency: store 2 cycles accept->done, load 3 cycles minimum; illegal/misaligned access done next cycle.
// Backpressure: one access in flight, start ignored while busy; mem_req held until mem_gnt; LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit #(
    parameter int unsigned RESP_TIMEOUT = 64   // max RESP cycles before err; 0 disables the timeout
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    input  logic [4:0]               rd_in,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     wb_en,
    output logic [4:0]               rd_out,
    output logic [31:0]              rdata_out,
    load_store_unit_if.master        mem
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
    // Count value on the last RESP cycle allowed before the access is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              legal_f3;
    logic              misalign;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;

    // Legality of the access presented on the request inputs (only meaningful on accept).
    always_comb begin
        legal_f3 = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                            : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Byte enables and lane-replicated write data from the latched access; loads use the same enables.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << {addr_q[1], 1'b0};
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    // Pick the addressed byte/half out of the returned word and extend it by funct3.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = mem.mem_rdata[7:0];
            2'b01:   ld_byte = mem.mem_rdata[15:8];
            2'b10:   ld_byte = mem.mem_rdata[23:16];
            default: ld_byte = mem.mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    // Next-state logic: accept/latch, request until grant, wait for response or timeout, one done cycle.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    rd_d       = rd_in;
                    rdata_d    = 32'h0;
                    cnt_d      = '0;
                    if (legal_f3 && !misalign) begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                // A response in the grant cycle is not expected and is not looked at.
                if (mem.mem_gnt) begin
                    state_d = is_store_q ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                if (mem.mem_rvalid) begin
                    rdata_d = ld_ext;
                    state_d = S_DONE;
                end else if ((RESP_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched-access registers; reset mid-access abandons the access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs decoded from state; everything is zero outside the cycles where it is valid.
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        err            = done && err_q;
        wb_en          = done && !err_q && !is_store_q;
        rd_out         = done ? rd_q : 5'd0;
        rdata_out      = (done && !err_q && !is_store_q) ? rdata_q : 32'h0;
        mem.mem_req    = (state_q == S_REQ);
        mem.mem_we     = mem.mem_req && is_store_q;
        mem.mem_addr   = mem.mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem.mem_be     = mem.mem_req ? lane_be : 4'b0000;
        mem.mem_wdata  = (mem.mem_req && is_store_q) ? lane_wdata : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected completions and memory requests.
// Latency: completion latency is checked against hand-computed values per access.
// Backpressure: grant and response delays are varied per access; start pulses while busy must be ignored.
module tb_load_store_unit;
    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic        err;
    logic        wb_en;
    logic [4:0]  rd_out;
    logic [31:0] rdata_out;

    load_store_unit_if mem_if ();

    load_store_unit #(.RESP_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wb_en     (wb_en),
        .rd_out    (rd_out),
        .rdata_out (rdata_out),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          start_cyc;
        int          lat;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    resp_t resp_q[$];
    mreq_t mreq_q[$];
    resp_t mon_r;
    mreq_t mon_m;
    int checks = 0;
    int errors = 0;
    int dones  = 0;
    int issued = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: compare every completion and every granted memory request against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && done) begin
            dones++;
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no completion", cyc);
            end else begin
                mon_r = resp_q.pop_front();
                chk("done_err", 32'(err), 32'(mon_r.err));
                chk("done_wb_en", 32'(wb_en), 32'(mon_r.wb_en));
                chk("done_rd_out", 32'(rd_out), 32'(mon_r.rd));
                chk("done_rdata_out", rdata_out, mon_r.rdata);
                chk("done_latency", 32'(cyc - mon_r.start_cyc), 32'(mon_r.lat));
                chk("done_busy", 32'(busy), 32'd1);
            end
        end
        if (mem_if.mem_req) begin
            if (mreq_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_req: got mem_req=1 at cycle %0d, required 0", cyc);
            end else if (mem_if.mem_gnt) begin
                mon_m = mreq_q.pop_front();
                chk("mem_we", 32'(mem_if.mem_we), 32'(mon_m.we));
                chk("mem_addr", mem_if.mem_addr, mon_m.addr);
                if (mon_m.we) begin
                    chk("mem_be", 32'(mem_if.mem_be), 32'(mon_m.be));
                    chk("mem_wdata", mem_if.mem_wdata, mon_m.wdata);
                end
            end
        end
    end

    // One access: issue, play the memory side, wait (bounded) for the unit to go idle.
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdat,
                          input logic mem_exp, input logic [3:0] e_be, input logic [31:0] e_wd,
                          input logic e_err, input logic [31:0] e_rdata, input int lat,
                          input logic poke);
        resp_t r;
        mreq_t m;
        int    n;
        @(posedge clk); #1;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; rd_in = rd;
        r.err = e_err; r.wb_en = !st && !e_err; r.rd = rd; r.rdata = e_rdata;
        r.start_cyc = cyc; r.lat = lat;
        resp_q.push_back(r);
        issued++;
        if (mem_exp) begin
            m.we = st; m.addr = {a[31:2], 2'b00}; m.be = e_be; m.wdata = e_wd;
            mreq_q.push_back(m);
        end
        @(posedge clk); #1;
        if (poke) begin
            addr = 32'hFFFF_FFFF; funct3 = 3'b011; rd_in = 5'd31; wdata = 32'h0; is_store = ~st;
        end else begin
            start = 1'b0;
        end
        if (mem_exp) begin
            repeat (gnt_dly) begin @(posedge clk); #1; end
            mem_if.mem_gnt = 1'b1;
            @(posedge clk); #1;
            mem_if.mem_gnt = 1'b0;
            start = 1'b0;
            if (!st && rv_dly > 0) begin
                repeat (rv_dly - 1) begin @(posedge clk); #1; end
                mem_if.mem_rdata = rdat; mem_if.mem_rvalid = 1'b1;
                @(posedge clk); #1;
                mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
            end
        end
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin @(posedge clk); #1; n++; end
        chk("idle_after_access", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("reset_rdata_out", rdata_out, 32'h0);
        rst_n = 1'b1;

        //     st  f3      addr          wdata         rd  gd rv rdata         mem be       exp_wdata     err e_rdata       lat poke
        access(1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 3, 0, 0, 32'h0,        1, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0,        2, 0);
        access(0, 3'b000, 32'h0000_0202, 32'h0,         5, 0, 3, 32'h12F0_5634, 1, 4'b0000, 32'h0,        0, 32'hFFFF_FFF0, 5, 0);
        access(0, 3'b100, 32'h0000_0202, 32'h0,         6, 2, 3, 32'h12F0_5634, 1, 4'b0000, 32'h0,        0, 32'h0000_00F0, 7, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        access(0, 3'b001, 32'h0000_0003, 32'h0,         9, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 32'h0,        1, 0);
        access(1, 3'b010, 32'h0000_0046, 32'hDEAD_BEEF, 4, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 32'h0,        1, 0);
`else
        access(0, 3'b001, 32'h0000_0003, 32'h0,         9, 0, 1, 32'hBEEF_1234, 1, 4'b0000, 32'h0,        0, 32'hFFFF_BEEF, 3, 0);
        access(1, 3'b010, 32'h0000_0046, 32'hDEAD_BEEF, 4, 0, 0, 32'h0,        1, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0,        2, 0);
`endif
        access(0, 3'b010, 32'h0000_0040, 32'h0,        10, 1, 2, 32'h89AB_CDEF, 1, 4'b0000, 32'h0,        0, 32'h89AB_CDEF, 5, 0);
        access(0, 3'b101, 32'h0000_0012, 32'h0,        11, 0, 1, 32'h8001_7FFF, 1, 4'b0000, 32'h0,        0, 32'h0000_8001, 3, 0);
        access(0, 3'b001, 32'h0000_0010, 32'h0,        14, 0, 1, 32'h0000_8001, 1, 4'b0000, 32'h0,        0, 32'hFFFF_8001, 3, 0);
        access(1, 3'b001, 32'h0000_0022, 32'h1234_BEEF, 2, 1, 0, 32'h0,        1, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0,        3, 0);
        access(1, 3'b010, 32'h0000_0044, 32'hDEAD_BEEF, 1, 0, 0, 32'h0,        1, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0,        2, 0);
        access(1, 3'b000, 32'h0000_0100, 32'h1234_567E, 8, 0, 0, 32'h0,        1, 4'b0001, 32'h7E7E_7E7E, 0, 32'h0,        2, 0);
        // Response never arrives: err after TMO RESP cycles.
        access(0, 3'b010, 32'h0000_0050, 32'h0,        15, 0, 0, 32'h0,        1, 4'b0000, 32'h0,        1, 32'h0,        6, 0);
        // Response on the last RESP cycle before the timeout still completes normally.
        access(0, 3'b000, 32'h0000_0001, 32'h0,        13, 0, 4, 32'h0000_7F00, 1, 4'b0000, 32'h0,        0, 32'h0000_007F, 6, 0);
        // Illegal funct3 for load and for store.
        access(0, 3'b011, 32'h0000_0070, 32'h0,        16, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 32'h0,        1, 0);
        access(1, 3'b100, 32'h0000_0074, 32'h5555_5555, 17, 0, 0, 32'h0,       0, 4'b0000, 32'h0,        1, 32'h0,        1, 0);
        // start held and inputs changed while busy: ignored, exactly one done with latched values.
        access(0, 3'b010, 32'h0000_0060, 32'h0,        12, 1, 2, 32'h0BAD_F00D, 1, 4'b0000, 32'h0,        0, 32'h0BAD_F00D, 5, 1);
        access(1, 3'b000, 32'h0000_0031, 32'h0000_0042, 18, 0, 0, 32'h0,       1, 4'b0010, 32'h4242_4242, 0, 32'h0,        2, 1);

        // Reset in the middle of a load's response wait.
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0080; rd_in = 5'd7;
        resp_q.push_back('{err: 1'b0, wb_en: 1'b1, rd: 5'd7, rdata: 32'h0, start_cyc: cyc, lat: 0});
        mreq_q.push_back('{we: 1'b0, addr: 32'h0000_0080, be: 4'b0000, wdata: 32'h0});
        @(posedge clk); #1;
        start = 1'b0; mem_if.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_if.mem_gnt = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_err", 32'(err), 32'd0);
        chk("midreset_wb_en", 32'(wb_en), 32'd0);
        chk("midreset_rd_out", 32'(rd_out), 32'd0);
        chk("midreset_rdata_out", rdata_out, 32'h0);
        chk("midreset_mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("midreset_mem_addr", mem_if.mem_addr, 32'h0);
        chk("midreset_mem_be", 32'(mem_if.mem_be), 32'd0);
        void'(resp_q.pop_back());
        d0 = dones;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
        repeat (6) @(posedge clk);
        #1;
        chk("stale_rvalid_no_done", 32'(dones), 32'(d0));
        chk("stale_rvalid_busy", 32'(busy), 32'd0);

        // Normal operation after the reset.
        access(1, 3'b010, 32'h0000_0008, 32'hA1B2_C3D4, 19, 0, 0, 32'h0,       1, 4'b1111, 32'hA1B2_C3D4, 0, 32'h0,        2, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("pending_responses", 32'(resp_q.size()), 32'd0);
        chk("pending_mem_reqs", 32'(mreq_q.size()), 32'd0);
        chk("done_count", 32'(dones), 32'(issued));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
